// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for a multicycle MIPS datapath (PC, IR, MDR, A, B, ALUOut
// registers). Drives per-register load enables, memory strobes, register
// file write controls and the ALU/PC mux selects. FETCH, MEM_READ and
// MEM_WRITE wait on mem_ready. Illegal opcodes and memory timeouts trap.
// Retired instructions are counted.
//
// Parameters
//   COUNT_W  width of instr_count (wraps modulo 2^COUNT_W)
//   TIMEOUT  consecutive mem_ready=0 cycles in a wait state before trapping;
//            0 disables the timeout
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   opcode, zero, mem_ready    IR[31:26], ALU zero flag, memory handshake
//   pc_en..aluout_en           register load enables
//   mem_read, mem_write, iord  memory strobes / address select (1 = ALUOut)
//   reg_write, reg_dst, mem_to_reg  register file write controls
//   alu_src_a, alu_src_b, alu_op, pc_src  datapath mux selects
//   state_o                    current state encoding
//   instr_done, instr_count    retire pulse and retired-instruction count
//   trap, trap_cause           trap flag and cause (01 illegal, 10 timeout)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int COUNT_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_en,
  output logic               mdr_en,
  output logic               a_en,
  output logic               b_en,
  output logic               aluout_en,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state_o,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The wait counter only has to reach TIMEOUT-1: the TIMEOUT-th idle cycle
  // is detected combinationally and traps on its closing edge.
  localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t              state_reg, state_next;
  logic [COUNT_W-1:0]  count_reg;
  logic [WAIT_W-1:0]   wait_reg, wait_next, wait_inc;
  logic [1:0]          cause_reg, cause_next;
  logic                timeout_hit;
  logic                done;

  // Saturating so a disabled timeout never wraps into a false match.
  assign wait_inc    = (wait_reg == {WAIT_W{1'b1}}) ? wait_reg : wait_reg + WAIT_W'(1);
  assign timeout_hit = (TIMEOUT > 0) && !mem_ready && (wait_reg == WAIT_W'(TO_LAST));

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    cause_next = cause_reg;
    wait_next  = '0;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else begin
          state_next = S_FETCH;
          wait_next  = wait_inc;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next = S_R_EXEC;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          OP_ADDI:       state_next = S_ADDI_EXEC;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      // Only lw/sw reach here, so anything other than sw is a load.
      S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else begin
          state_next = S_MEM_READ;
          wait_next  = wait_inc;
        end
      end
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else begin
          state_next = S_MEM_WRITE;
          wait_next  = wait_inc;
        end
      end
      S_R_EXEC:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_ADDI_WB:   state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_FETCH;
    endcase
  end

  // State, counters and trap cause
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
      wait_reg  <= '0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      cause_reg <= cause_next;
      if (done) begin
        count_reg <= count_reg + COUNT_W'(1);
      end
    end
  end

  // Output decode; everything is forced low while reset is asserted so no
  // strobe escapes during the reset cycle, even from a wait state.
  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mdr_en     = 1'b0;
    a_en       = 1'b0;
    b_en       = 1'b0;
    aluout_en  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    done       = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_en     = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          a_en      = 1'b1;
          b_en      = 1'b1;
          aluout_en = 1'b1;
          alu_src_b = 2'b11;
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluout_en = 1'b1;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mdr_en   = mem_ready;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          done       = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          done      = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          aluout_en = 1'b1;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          done      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_en     = zero;
          done      = 1'b1;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
          done   = 1'b1;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_done  = done;
  assign state_o     = reset ? 4'd0 : state_reg;
  assign instr_count = reset ? '0 : count_reg;
  assign trap        = !reset && (state_reg == S_TRAP);
  assign trap_cause  = reset ? 2'b00 : cause_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed bench for mips_multicycle_ctrl (COUNT_W=4, TIMEOUT=16). Inputs are
// driven on the falling edge and outputs sampled 1 ns later, so each sample
// shows the combinational decode of the state entered on the previous rising
// edge. Control outputs are packed into one 19-bit word for comparison.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_en, mdr_en, a_en, b_en, aluout_en;
  logic       mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;
  logic       instr_done;
  logic [3:0] instr_count;
  logic       trap;
  logic [1:0] trap_cause;

  int n_checks = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl #(.COUNT_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .mdr_en(mdr_en), .a_en(a_en), .b_en(b_en),
    .aluout_en(aluout_en), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state_o(state_o), .instr_done(instr_done), .instr_count(instr_count),
    .trap(trap), .trap_cause(trap_cause)
  );

  // {pc_en ir_en mdr_en a_en b_en aluout_en | mem_read mem_write iord |
  //  reg_write reg_dst mem_to_reg | src_a | src_b | alu_op | pc_src}
  logic [18:0] ctl;
  assign ctl = {pc_en, ir_en, mdr_en, a_en, b_en, aluout_en, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  localparam logic [18:0] C_ZERO    = 19'b0;
  localparam logic [18:0] C_FETCH_R = 19'b110000_100_000_0_01_00_00;
  localparam logic [18:0] C_FETCH_W = 19'b000000_100_000_0_01_00_00;
  localparam logic [18:0] C_DECODE  = 19'b000111_000_000_0_11_00_00;
  localparam logic [18:0] C_ADDR    = 19'b000001_000_000_1_10_00_00;
  localparam logic [18:0] C_MR_R    = 19'b001000_101_000_0_00_00_00;
  localparam logic [18:0] C_MR_W    = 19'b000000_101_000_0_00_00_00;
  localparam logic [18:0] C_MWB     = 19'b000000_000_101_0_00_00_00;
  localparam logic [18:0] C_MW      = 19'b000000_011_000_0_00_00_00;
  localparam logic [18:0] C_REXEC   = 19'b000001_000_000_1_00_10_00;
  localparam logic [18:0] C_RWB     = 19'b000000_000_110_0_00_00_00;
  localparam logic [18:0] C_BR1     = 19'b100000_000_000_1_00_01_01;
  localparam logic [18:0] C_BR0     = 19'b000000_000_000_1_00_01_01;
  localparam logic [18:0] C_JUMP    = 19'b100000_000_000_0_00_00_10;
  localparam logic [18:0] C_AWB     = 19'b000000_000_100_0_00_00_00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want $finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b100011; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (ctl !== C_ZERO) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_ZERO); end
    n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_checks++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", instr_done); end
    n_checks++; if (instr_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    n_checks++; if ({trap, trap_cause} !== 3'b000) begin n_fail++; $display("FAIL reset_trap: got %b want 000", {trap, trap_cause}); end
    $display("reset: held 2 cycles, outputs %b", ctl);
  endtask

  // Runs one instruction given per-cycle expectations; reset is released on the first cycle.
  task automatic test_rtype();
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [18:0] cw [4] = '{C_FETCH_R, C_DECODE, C_REXEC, C_RWB};
    logic        dn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); reset = 1'b0; opcode = 6'b000000; mem_ready = 1'b1; zero = 1'b0; #1;
      n_checks++; if (state_o !== st[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
      n_checks++; if (ctl !== cw[i]) begin n_fail++; $display("FAIL rtype_ctl[%0d]: got %b want %b", i, ctl, cw[i]); end
      n_checks++; if (instr_done !== dn[i]) begin n_fail++; $display("FAIL rtype_done[%0d]: got %b want %b", i, instr_done, dn[i]); end
      n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL rtype_trap[%0d]: got %b want 0", i, trap); end
    end
    @(posedge clk); #1;
    n_checks++; if (instr_count !== 4'd1) begin n_fail++; $display("FAIL rtype_count: got %0d want 1", instr_count); end
    $display("rtype: states 0,1,6,7 count=%0d", instr_count);
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [18:0] cw [8] = '{C_FETCH_R, C_DECODE, C_ADDR, C_MR_W, C_MR_W, C_MR_W, C_MR_R, C_MWB};
    logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        dn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); opcode = 6'b100011; mem_ready = mr[i]; #1;
      n_checks++; if (state_o !== st[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
      n_checks++; if (ctl !== cw[i]) begin n_fail++; $display("FAIL lw_ctl[%0d]: got %b want %b", i, ctl, cw[i]); end
      n_checks++; if (instr_done !== dn[i]) begin n_fail++; $display("FAIL lw_done[%0d]: got %b want %b", i, instr_done, dn[i]); end
    end
    @(posedge clk); #1;
    n_checks++; if (instr_count !== 4'd2) begin n_fail++; $display("FAIL lw_count: got %0d want 2", instr_count); end
    $display("lw: 3 wait cycles in MEM_READ, count=%0d", instr_count);
  endtask

  task automatic test_beq();
    logic [18:0] brw [2] = '{C_BR1, C_BR0};
    logic [3:0]  cnt [2] = '{4'd3, 4'd4};
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); opcode = 6'b000100; mem_ready = 1'b1; zero = (b == 0); #1;
      n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL beq%0d_fetch: got %0d want 0", b, state_o); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL beq%0d_decode: got %0d want 1", b, state_o); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== 4'd8) begin n_fail++; $display("FAIL beq%0d_state: got %0d want 8", b, state_o); end
      n_checks++; if (ctl !== brw[b]) begin n_fail++; $display("FAIL beq%0d_ctl: got %b want %b", b, ctl, brw[b]); end
      n_checks++; if (instr_done !== 1'b1) begin n_fail++; $display("FAIL beq%0d_done: got %b want 1", b, instr_done); end
      @(posedge clk); #1;
      n_checks++; if (instr_count !== cnt[b]) begin n_fail++; $display("FAIL beq%0d_count: got %0d want %0d", b, instr_count, cnt[b]); end
      $display("beq: zero=%0d pc_en=%b count=%0d", (b == 0), brw[b][18], instr_count);
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
    logic [18:0] cw [4] = '{C_FETCH_R, C_DECODE, C_ADDR, C_AWB};
    logic        dn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); opcode = 6'b001000; mem_ready = 1'b1; #1;
      n_checks++; if (state_o !== st[i]) begin n_fail++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
      n_checks++; if (ctl !== cw[i]) begin n_fail++; $display("FAIL addi_ctl[%0d]: got %b want %b", i, ctl, cw[i]); end
      n_checks++; if (instr_done !== dn[i]) begin n_fail++; $display("FAIL addi_done[%0d]: got %b want %b", i, instr_done, dn[i]); end
    end
    @(posedge clk); #1;
    n_checks++; if (instr_count !== 4'd5) begin n_fail++; $display("FAIL addi_count: got %0d want 5", instr_count); end
    $display("addi: states 0,1,10,11 count=%0d", instr_count);
  endtask

  task automatic test_sw();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic [18:0] cw [5] = '{C_FETCH_R, C_DECODE, C_ADDR, C_MW, C_MW};
    logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        dn [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); opcode = 6'b101011; mem_ready = mr[i]; #1;
      n_checks++; if (state_o !== st[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
      n_checks++; if (ctl !== cw[i]) begin n_fail++; $display("FAIL sw_ctl[%0d]: got %b want %b", i, ctl, cw[i]); end
      n_checks++; if (instr_done !== dn[i]) begin n_fail++; $display("FAIL sw_done[%0d]: got %b want %b", i, instr_done, dn[i]); end
    end
    @(posedge clk); #1;
    n_checks++; if (instr_count !== 4'd6) begin n_fail++; $display("FAIL sw_count: got %0d want 6", instr_count); end
    $display("sw: 1 wait cycle in MEM_WRITE, count=%0d", instr_count);
  endtask

  // Leaves reset asserted; the next task releases it.
  task automatic test_reset_mid_write();
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic       mr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); opcode = 6'b101011; mem_ready = mr[i]; #1;
      n_checks++; if (state_o !== st[i]) begin n_fail++; $display("FAIL midrst_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
    end
    @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
    n_checks++; if (ctl !== C_ZERO) begin n_fail++; $display("FAIL midrst_ctl: got %b want %b", ctl, C_ZERO); end
    n_checks++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", instr_done); end
    $display("reset asserted mid MEM_WRITE, outputs %b", ctl);
  endtask

  task automatic test_jump_wrap();
    for (int j = 0; j < 17; j++) begin
      @(negedge clk); reset = 1'b0; opcode = 6'b000010; mem_ready = 1'b1; #1;
      n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL jump%0d_fetch: got %0d want 0", j, state_o); end
      n_checks++; if (instr_count !== 4'(j)) begin n_fail++; $display("FAIL jump%0d_count: got %0d want %0d", j, instr_count, 4'(j)); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL jump%0d_decode: got %0d want 1", j, state_o); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== 4'd9) begin n_fail++; $display("FAIL jump%0d_state: got %0d want 9", j, state_o); end
      n_checks++; if (ctl !== C_JUMP) begin n_fail++; $display("FAIL jump%0d_ctl: got %b want %b", j, ctl, C_JUMP); end
      n_checks++; if (instr_done !== 1'b1) begin n_fail++; $display("FAIL jump%0d_done: got %b want 1", j, instr_done); end
      $display("jump %0d: count before retire=%0d", j, instr_count);
    end
    @(posedge clk); #1;
    n_checks++; if (instr_count !== 4'd1) begin n_fail++; $display("FAIL jump_wrap_count: got %0d want 1", instr_count); end
  endtask

  task automatic test_illegal();
    @(negedge clk); opcode = 6'b111111; mem_ready = 1'b1; #1;
    n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL ill_fetch: got %0d want 0", state_o); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== C_DECODE) begin n_fail++; $display("FAIL ill_decode_ctl: got %b want %b", ctl, C_DECODE); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); opcode = 6'b000000; zero = 1'b1; mem_ready = i[0]; #1;
      n_checks++; if (state_o !== 4'd12) begin n_fail++; $display("FAIL ill_state[%0d]: got %0d want 12", i, state_o); end
      n_checks++; if ({trap, trap_cause} !== 3'b101) begin n_fail++; $display("FAIL ill_trap[%0d]: got %b want 101", i, {trap, trap_cause}); end
      n_checks++; if (ctl !== C_ZERO) begin n_fail++; $display("FAIL ill_ctl[%0d]: got %b want %b", i, ctl, C_ZERO); end
      n_checks++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL ill_done[%0d]: got %b want 0", i, instr_done); end
    end
    n_checks++; if (instr_count !== 4'd1) begin n_fail++; $display("FAIL ill_count: got %0d want 1", instr_count); end
    zero = 1'b0;
    $display("illegal opcode: trap=%b cause=%b", trap, trap_cause);
  endtask

  // Asserts reset for one edge out of any state; the next task releases it.
  task automatic test_reset_from_trap();
    @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
    n_checks++; if ({trap, trap_cause} !== 3'b000) begin n_fail++; $display("FAIL trap_rst: got %b want 000", {trap, trap_cause}); end
    n_checks++; if (ctl !== C_ZERO) begin n_fail++; $display("FAIL trap_rst_ctl: got %b want %b", ctl, C_ZERO); end
    $display("reset asserted from trap");
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); reset = 1'b0; opcode = 6'b000000; mem_ready = 1'b0; #1;
      n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL to_wait_state[%0d]: got %0d want 0", k, state_o); end
      n_checks++; if (ctl !== C_FETCH_W) begin n_fail++; $display("FAIL to_wait_ctl[%0d]: got %b want %b", k, ctl, C_FETCH_W); end
    end
    @(negedge clk); #1;
    n_checks++; if (state_o !== 4'd12) begin n_fail++; $display("FAIL to_state: got %0d want 12", state_o); end
    n_checks++; if ({trap, trap_cause} !== 3'b110) begin n_fail++; $display("FAIL to_trap: got %b want 110", {trap, trap_cause}); end
    n_checks++; if (ctl !== C_ZERO) begin n_fail++; $display("FAIL to_ctl: got %b want %b", ctl, C_ZERO); end
    $display("timeout: 16 idle cycles in FETCH, trap=%b cause=%b", trap, trap_cause);
  endtask

  task automatic test_ready_on_last();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); reset = 1'b0; opcode = 6'b000000; mem_ready = 1'b0; #1;
      n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL rl_wait_state[%0d]: got %0d want 0", k, state_o); end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    n_checks++; if (ctl !== C_FETCH_R) begin n_fail++; $display("FAIL rl_ctl: got %b want %b", ctl, C_FETCH_R); end
    @(negedge clk); #1;
    n_checks++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL rl_state: got %0d want 1", state_o); end
    n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL rl_trap: got %b want 0", trap); end
    $display("ready on 16th FETCH cycle: state=%0d", state_o);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_addi();
    test_sw();
    test_reset_mid_write();
    test_jump_wrap();
    test_illegal();
    test_reset_from_trap();
    test_timeout();
    test_reset_from_trap();
    test_ready_on_last();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
